outport_sw_scheduler: RTL and testbench

- Per-output-port switch scheduler for the NoC router; one instance per output port.
- Shares the output port among the P-1 other input ports using round-robin arbitration.
- Tracks downstream credits for each output VC and only grants when the requested VC has credit.
- Holds the port locked to one input from a packet's first granted flit until its tail flit is granted, so packets are never interleaved on the crossbar output.

---
 rtl/outport_sw_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_outport_sw_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/outport_sw_scheduler.sv
// outport_sw_scheduler
//   Switch allocator for one router output port. Up to P-1 input ports
//   compete for the port under round-robin arbitration. A grant is only
//   issued when the requested downstream VC has credit. With LOCK_EN set,
//   the port stays with one input from a packet's head flit until its tail
//   flit, so packets never interleave on the crossbar output.
//
// Ports
//   clk           clock
//   reset         asynchronous reset, active low
//   req           per-input request, held until granted
//   req_vc        per-input one-hot output VC, slice i = [i*V +: V]
//   req_tail      requesting flit is a tail (single-flit packets set it)
//   credit_in     one-cycle credit return pulse per downstream VC
//   grant         one-hot grant, combinational
//   ovc_not_full  per-VC credit available (credit_cnt != 0)
//   locked        port is held by an in-flight packet
//   credit_err    one-cycle pulse after a credit return hits a full counter
//
// state     | meaning
// ST_OPEN   | no packet in flight, round-robin among eligible inputs
// ST_LOCKED | packet in flight from lock_idx_q, only that input may win

module outport_sw_scheduler #(
   parameter int V       = 4,
   parameter int P       = 5,
   parameter int B       = 4,
   parameter bit LOCK_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [P-2:0]         req,
   input  logic [(P-1)*V-1:0]   req_vc,
   input  logic [P-2:0]         req_tail,
   input  logic [V-1:0]         credit_in,
   output logic [P-2:0]         grant,
   output logic [V-1:0]         ovc_not_full,
   output logic                 locked,
   output logic                 credit_err
);

   localparam int P_1 = P - 1;
   localparam int PW  = (P_1 > 1) ? $clog2(P_1) : 1;
   localparam int CW  = $clog2(B + 1);

   typedef enum logic {
      ST_OPEN   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   lock_idx_q, lock_idx_d;
   logic [PW-1:0]   rr_ptr, rr_ptr_d;
   logic [CW-1:0]   credit_cnt [V];
   logic [CW-1:0]   credit_d   [V];
   logic [V-1:0]    credit_ovf;
   logic            credit_err_q;

   logic [V-1:0]    vc_sel [P_1];
   logic [P_1-1:0]  elig;
   logic            xfer;
   logic [PW-1:0]   xfer_idx;
   logic [V-1:0]    xfer_vc;
   logic [V-1:0]    cr_dec;

   // First set bit of e at or after ptr, wrapping modulo P_1.
   function automatic logic [P_1-1:0] rr_pick(input logic [P_1-1:0] e,
                                               input logic [PW-1:0]  ptr);
      logic [P_1-1:0] g;
      logic           found;
      logic [PW-1:0]  idx;
      g     = '0;
      found = 1'b0;
      for (int k = 0; k < P_1; k++) begin
         idx = PW'((int'(ptr) + k) % P_1);
         if (!found && e[idx]) begin
            g[idx] = 1'b1;
            found  = 1'b1;
         end
      end
      return g;
   endfunction

   always_comb begin
      for (int v = 0; v < V; v++) begin
         ovc_not_full[v] = (credit_cnt[v] != '0);
      end
   end

   // A zero or multi-hot VC select is treated as an illegal request.
   always_comb begin
      elig = '0;
      for (int i = 0; i < P_1; i++) begin
         vc_sel[i] = req_vc[i*V +: V];
         elig[i]   = req[i]
                     && (vc_sel[i] != '0)
                     && ((vc_sel[i] & (vc_sel[i] - V'(1))) == '0)
                     && ((vc_sel[i] & ovc_not_full) != '0);
      end
   end

   always_comb begin
      grant = '0;
      if (!reset) begin
         grant = '0;
      end else if (state_q == ST_LOCKED) begin
         grant[lock_idx_q] = elig[lock_idx_q];
      end else begin
         grant = rr_pick(elig, rr_ptr);
      end
   end

   always_comb begin
      xfer     = |grant;
      xfer_idx = '0;
      xfer_vc  = '0;
      for (int i = 0; i < P_1; i++) begin
         if (grant[i]) begin
            xfer_idx = PW'(i);
            xfer_vc  = vc_sel[i];
         end
      end
      cr_dec = {V{xfer}} & xfer_vc;
   end

   // A decrement and a return on the same edge cancel out.
   always_comb begin
      credit_ovf = '0;
      for (int v = 0; v < V; v++) begin
         credit_d[v] = credit_cnt[v];
         if (cr_dec[v] && !credit_in[v]) begin
            credit_d[v] = credit_cnt[v] - CW'(1);
         end else if (credit_in[v] && !cr_dec[v]) begin
            if (credit_cnt[v] == CW'(B)) begin
               credit_ovf[v] = 1'b1;
            end else begin
               credit_d[v] = credit_cnt[v] + CW'(1);
            end
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr;
      if (xfer) begin
         rr_ptr_d = (xfer_idx == PW'(P_1 - 1)) ? '0 : xfer_idx + PW'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      lock_idx_d = lock_idx_q;
      if (xfer) begin
         if (req_tail[xfer_idx]) begin
            state_d = ST_OPEN;
         end else if (LOCK_EN) begin
            state_d    = ST_LOCKED;
            lock_idx_d = xfer_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_OPEN;
         lock_idx_q   <= '0;
         rr_ptr       <= '0;
         credit_err_q <= 1'b0;
         for (int v = 0; v < V; v++) begin
            credit_cnt[v] <= CW'(B);
         end
      end else begin
         state_q      <= state_d;
         lock_idx_q   <= lock_idx_d;
         rr_ptr       <= rr_ptr_d;
         credit_err_q <= |credit_ovf;
         for (int v = 0; v < V; v++) begin
            credit_cnt[v] <= credit_d[v];
         end
      end
   end

   assign locked     = (state_q == ST_LOCKED);
   assign credit_err = credit_err_q;

endmodule

// File: tb/tb_outport_sw_scheduler.sv
// tb_outport_sw_scheduler
//   Drives outport_sw_scheduler with directed sequences followed by random
//   traffic and compares grant and the registered outputs each cycle
//   against a behavioural model of the arbitration and credit rules.

module tb_outport_sw_scheduler;

   localparam int V   = 4;
   localparam int P   = 5;
   localparam int P_1 = P - 1;
   localparam int B   = 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [P_1-1:0]       req;
   logic [P_1*V-1:0]     req_vc;
   logic [P_1-1:0]       req_tail;
   logic [V-1:0]         credit_in;
   logic [P_1-1:0]       grant;
   logic [V-1:0]         ovc_not_full;
   logic                 locked;
   logic                 credit_err;

   int n_vec = 0;
   int n_err = 0;

   int m_cnt [V];
   int m_rr;
   bit m_lk;
   int m_lidx;
   bit m_err;

   outport_sw_scheduler #(.V(V), .P(P), .B(B), .LOCK_EN(1'b1)) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .req_vc       (req_vc),
      .req_tail     (req_tail),
      .credit_in    (credit_in),
      .grant        (grant),
      .ovc_not_full (ovc_not_full),
      .locked       (locked),
      .credit_err   (credit_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Selected VC index, or -1 when the slice is not exactly one-hot.
   function automatic int vc_of(input logic [V-1:0] s);
      int n, idx;
      n   = 0;
      idx = -1;
      for (int v = 0; v < V; v++) begin
         if (s[v]) begin
            n++;
            idx = v;
         end
      end
      return (n == 1) ? idx : -1;
   endfunction

   function automatic bit m_elig(input int i);
      int vc;
      vc = vc_of(req_vc[i*V +: V]);
      return req[i] && (vc >= 0) && (m_cnt[vc] > 0);
   endfunction

   function automatic logic [P_1-1:0] m_grant();
      logic [P_1-1:0] g;
      int i;
      g = '0;
      if (reset !== 1'b1) return g;
      if (m_lk) begin
         if (m_elig(m_lidx)) g[m_lidx] = 1'b1;
         return g;
      end
      for (int k = 0; k < P_1; k++) begin
         i = (m_rr + k) % P_1;
         if (m_elig(i)) begin
            g[i] = 1'b1;
            return g;
         end
      end
      return g;
   endfunction

   task automatic m_reset();
      for (int v = 0; v < V; v++) m_cnt[v] = B;
      m_rr   = 0;
      m_lk   = 1'b0;
      m_lidx = 0;
      m_err  = 1'b0;
   endtask

   task automatic m_clock(input logic [P_1-1:0] g);
      int gi, gv;
      bit dec, inc;
      gi = -1;
      gv = -1;
      for (int i = 0; i < P_1; i++) begin
         if (g[i]) begin
            gi = i;
            gv = vc_of(req_vc[i*V +: V]);
         end
      end
      m_err = 1'b0;
      for (int v = 0; v < V; v++) begin
         dec = (gv == v);
         inc = credit_in[v];
         if (dec && !inc) m_cnt[v] = m_cnt[v] - 1;
         else if (inc && !dec) begin
            if (m_cnt[v] == B) m_err = 1'b1;
            else m_cnt[v] = m_cnt[v] + 1;
         end
      end
      if (gi >= 0) begin
         m_rr = (gi + 1) % P_1;
         if (req_tail[gi]) m_lk = 1'b0;
         else begin
            m_lk   = 1'b1;
            m_lidx = gi;
         end
      end
   endtask

   task automatic check_state();
      logic [V-1:0] nf;
      for (int v = 0; v < V; v++) nf[v] = (m_cnt[v] != 0);
      chk("ovc_not_full", 32'(ovc_not_full), 32'(nf));
      chk("locked", 32'(locked), 32'(m_lk));
      chk("credit_err", 32'(credit_err), 32'(m_err));
   endtask

   // One clock cycle: apply inputs, compare at the falling edge, then
   // advance the model on the rising edge.
   task automatic cyc(input logic [P_1-1:0] r, input logic [P_1*V-1:0] vc,
                      input logic [P_1-1:0] t, input logic [V-1:0] c);
      logic [P_1-1:0] g;
      req       = r;
      req_vc    = vc;
      req_tail  = t;
      credit_in = c;
      @(negedge clk);
      g = m_grant();
      chk("grant", 32'(grant), 32'(g));
      check_state();
      @(posedge clk);
      m_clock(g);
      #1;
   endtask

   function automatic logic [V-1:0] rand_vc();
      int k;
      k = $urandom_range(0, 9);
      if (k < 8) return V'(1) << (k % V);
      if (k == 8) return '0;
      return V'(4'b0110);
   endfunction

   initial begin
      logic [P_1*V-1:0] rvc;
      logic [V-1:0]     rc;

      reset     = 1'b0;
      req       = '1;
      req_vc    = 16'h1111;
      req_tail  = '1;
      credit_in = '0;
      m_reset();
      #12;
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_ovc_not_full", 32'(ovc_not_full), 32'hf);
      chk("rst_locked", 32'(locked), 32'h0);
      chk("rst_credit_err", 32'(credit_err), 32'h0);

      req = '0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // round robin over all four inputs, credit returned every cycle
      repeat (5) cyc(4'b1111, 16'h1111, 4'b1111, 4'b0001);

      // exhaust VC2 from input 0, then return one credit
      repeat (5) cyc(4'b0001, 16'h0004, 4'b0001, 4'b0000);
      cyc(4'b0001, 16'h0004, 4'b0001, 4'b0100);
      cyc(4'b0001, 16'h0004, 4'b0001, 4'b0000);

      // VC1 down to two credits, then grant and return on the same edge
      repeat (2) cyc(4'b0001, 16'h0002, 4'b0001, 4'b0000);
      cyc(4'b0001, 16'h0002, 4'b0001, 4'b0010);
      cyc(4'b0000, 16'h0000, 4'b0000, 4'b0000);

      // packet lock: input 2 head/stall/body/stall/tail, input 0 competing
      cyc(4'b0101, 16'h0101, 4'b0001, 4'b0000);
      cyc(4'b0001, 16'h0101, 4'b0001, 4'b0000);
      cyc(4'b0101, 16'h0101, 4'b0001, 4'b0000);
      cyc(4'b0001, 16'h0101, 4'b0001, 4'b0000);
      cyc(4'b0101, 16'h0101, 4'b0101, 4'b0000);
      cyc(4'b0001, 16'h0101, 4'b0001, 4'b0001);

      // overflow on VC3 and an illegal multi-hot request from input 1
      cyc(4'b0000, 16'h0000, 4'b0000, 4'b1000);
      cyc(4'b0010, 16'h0060, 4'b0010, 4'b0000);
      cyc(4'b0010, 16'h0060, 4'b0010, 4'b0000);

      // lock input 1 on VC0, then reset asynchronously mid-packet
      cyc(4'b0010, 16'h0010, 4'b0000, 4'b0001);
      cyc(4'b0000, 16'h0000, 4'b0000, 4'b0000);
      #2;
      reset = 1'b0;
      #1;
      m_reset();
      chk("async_rst_locked", 32'(locked), 32'h0);
      chk("async_rst_ovc_not_full", 32'(ovc_not_full), 32'hf);
      chk("async_rst_grant", 32'(grant), 32'h0);
      req = '0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      cyc(4'b1111, 16'h1111, 4'b1111, 4'b0000);

      // random traffic
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < P_1; i++) rvc[i*V +: V] = rand_vc();
         for (int v = 0; v < V; v++) rc[v] = ($urandom_range(0, 2) == 0);
         cyc(P_1'($urandom), rvc, P_1'($urandom), rc);
      end

      @(negedge clk);
      check_state();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
